accum_xcel_sched: RTL and testbench
===================================

# accum_xcel_sched

Job scheduler that sequences the accumulate accelerator (`AccumXcel`) on behalf of the processor. It queues tagged accumulate requests, launches them one at a time over the accelerator's val/rdy start interface, and detects completion. It captures each 32-bit result and returns it with its tag over a val/rdy response interface. The block sits between the processor's accelerator port and a single `AccumXcel` instance.

## Interface
- `DEPTH`, 4, job-queue entries; power of two, at least 2
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_val`  in  1  request valid
- `req_rdy`  out  1  request ready; equals queue not full
- `req_size`  in  7  number of words to accumulate from address 0x000
- `req_tag`  in  4  requester tag, returned with the result
- `resp_val`  out  1  response valid
- `resp_rdy`  in  1  response ready
- `resp_result`  out  32  accumulated sum
- `resp_tag`  out  4  tag of the completed job
- `xcel_in_val`  out  1  start request to the accelerator
- `xcel_in_rdy`  in  1  accelerator idle / result valid
- `xcel_in_size`  out  7  size sent to the accelerator
- `xcel_result`  in  32  accelerator result
- `done_count`  out  16  completed-and-delivered job count; wraps modulo 2^16

## Operation
- Queue: FIFO of {tag, size}, DEPTH entries, with a count register of width clog2(DEPTH)+1.
  - Push on `req_val && req_rdy`.
  - `req_rdy = (count != DEPTH)`. A pop in the same cycle does not free a slot for a push.
- FSM states: IDLE, BUSY, WAIT, RESP.
- IDLE
  - `xcel_in_val = (count != 0)`; `xcel_in_size` = head size.
  - On `xcel_in_val && xcel_in_rdy`: pop the head, latch its tag into `cur_tag`, go to BUSY.
- BUSY
  - One-cycle guard. `xcel_in_rdy` is ignored, because the accelerator drops rdy after accepting.
  - Always go to WAIT.
- WAIT
  - `xcel_in_val = 0`.
  - When `xcel_in_rdy = 1`: register `xcel_result` into `resp_result` and `cur_tag` into `resp_tag`, then go to RESP.
- RESP
  - `resp_val = 1`; `resp_result` and `resp_tag` are held stable.
  - On `resp_rdy`: increment `done_count`, go to IDLE.
- Exactly one job is in flight. Responses return in request order.
- Size 0 is forwarded unchanged and yields result 0.
- Requests are accepted in any state while the queue is not full. Up to DEPTH+1 jobs are outstanding (DEPTH queued plus 1 in flight).
- `resp_result` and `resp_tag` keep their last values outside RESP. Only `resp_val` qualifies them.

## Timing
- Reset (asynchronous on `rst_n = 0`) sets:
  - state to IDLE; queue empty; `req_rdy = 1`
  - `resp_val = 0`, `resp_result = 0`, `resp_tag = 0`
  - `xcel_in_val = 0`, `xcel_in_size = 0`, `done_count = 0`
- `xcel_in_size` equals the head size when the queue is non-empty, otherwise 0.
- Reset mid-job drops every queued and in-flight job with no response. The accelerator is reset by the same event via inverted `rst_n`.
- Latency from an accepted request (cycle 0) with an empty queue and IDLE state:
  - `xcel_in_val = 1` in cycle 1; handshake in cycle 1 when the accelerator is idle.
  - BUSY in cycle 2; WAIT from cycle 3.
  - `resp_val` rises the cycle after `xcel_in_rdy` is seen high in WAIT.
- Back-to-back jobs: the next `xcel_in_val` is asserted in the cycle after the `resp_val && resp_rdy` handshake, at the earliest.
- All outputs except `req_rdy`, `xcel_in_val` and `xcel_in_size` are registered. Those three are combinational from state/count/head only, with no input-to-output path.
- Simultaneous push and pop on a non-full queue: count is unchanged and both take effect.

## Test plan
Memory words 0x000..0x00c hold 1, 2, 3, 4. The real `AccumXcel` and the test memory are attached.
- Reset: `rst_n = 0`, then release → `req_rdy = 1`, `resp_val = 0`, `xcel_in_val = 0`, `done_count = 0`, `resp_result = 0`.
- Single job: size 4, tag 3 → `xcel_in_val = 1`, `xcel_in_size = 4` one cycle later. Eventually `resp_val = 1`, `resp_result = 10`, `resp_tag = 3`. With `resp_rdy = 1`, `done_count = 1`.
- Back-to-back jobs, size 4 tag 1 then size 2 tag 2 on consecutive cycles:
  - Responses in order: (10, tag 1), then (3, tag 2).
  - The second `xcel_in_val` rises only after the first response handshake.
- Queue full: hold `resp_rdy = 0` and offer 6 requests, sizes 1..4 with tags 0..5 → 5 accepted, then `req_rdy = 0`. After draining, results are 1, 3, 6, 10, 1 with tags 0..4.
- Backpressure and size 0:
  - Size 0, tag 7 with `resp_rdy = 0` for 10 cycles → `resp_val`, `resp_result = 0` and `resp_tag = 7` stay stable; `xcel_in_val = 0` throughout.
  - Then `resp_rdy = 1` → `resp_val = 0` the next cycle.
- Reset mid-WAIT: size 4 job, assert `rst_n = 0` during WAIT → all outputs return to reset values immediately. No response ever appears. A new size 1 request then yields 1.

Source files
------------

// File: rtl/accum_xcel_sched.sv
// accum_xcel_sched: queues tagged accumulate jobs, launches them one at a
// time on the AccumXcel start interface, captures each result and returns
// it with its tag over a val/rdy response port.
module accum_xcel_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [6:0]  req_size,
  input  logic [3:0]  req_tag,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_result,
  output logic [3:0]  resp_tag,
  output logic        xcel_in_val,
  input  logic        xcel_in_rdy,
  output logic [6:0]  xcel_in_size,
  input  logic [31:0] xcel_result,
  output logic [15:0] done_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [6:0]    size_mem [DEPTH];
  logic [3:0]    tag_mem  [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    cur_tag;
  logic          empty;
  logic          push;
  logic          pop;

  // Ready depends only on the registered count, so a same-cycle pop never
  // opens a slot for a push and there is no input-to-output path.
  assign empty        = (count == '0);
  assign req_rdy      = (count != CW'(DEPTH));
  assign push         = req_val && req_rdy;
  assign xcel_in_val  = (state == IDLE) && !empty;
  assign xcel_in_size = empty ? 7'd0 : size_mem[rd_ptr];
  assign pop          = xcel_in_val && xcel_in_rdy;
  assign resp_val     = (state == RESP);

  // Job storage: payload only, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      size_mem[wr_ptr] <= req_size;
      tag_mem[wr_ptr]  <= req_tag;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job sequencing: launch, one guard cycle while the accelerator drops rdy, wait, respond.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = BUSY;
      BUSY:    state_next = WAIT;
      WAIT:    if (xcel_in_rdy) state_next = RESP;
      RESP:    if (resp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, in-flight tag, held response payload and delivered-job counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_tag     <= '0;
      resp_result <= '0;
      resp_tag    <= '0;
      done_count  <= '0;
    end else begin
      state <= state_next;
      if (pop) cur_tag <= tag_mem[rd_ptr];
      if ((state == WAIT) && xcel_in_rdy) begin
        resp_result <= xcel_result;
        resp_tag    <= cur_tag;
      end
      if ((state == RESP) && resp_rdy) done_count <= done_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_accum_xcel_sched.sv
// Testbench for accum_xcel_sched with a behavioural AccumXcel stand-in
// over a memory holding 1, 2, 3, 4 at word addresses 0..3.
module tb_accum_xcel_sched;

  logic        clk;
  logic        rst_n;
  logic        req_val;
  logic        req_rdy;
  logic [6:0]  req_size;
  logic [3:0]  req_tag;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_result;
  logic [3:0]  resp_tag;
  logic        xcel_in_val;
  logic        xcel_in_rdy;
  logic [6:0]  xcel_in_size;
  logic [31:0] xcel_result;
  logic [15:0] done_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t model_q[$];

  accum_xcel_sched #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_size(req_size), .req_tag(req_tag),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_result(resp_result), .resp_tag(resp_tag),
    .xcel_in_val(xcel_in_val), .xcel_in_rdy(xcel_in_rdy), .xcel_in_size(xcel_in_size),
    .xcel_result(xcel_result), .done_count(done_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Sum of the first n memory words; words beyond address 0x00c read as 0.
  function automatic logic [31:0] mem_sum(input logic [6:0] n);
    logic [31:0] s = 0;
    for (int i = 0; i < int'(n); i++) s += (i < 4) ? 32'(i + 1) : 32'd0;
    return s;
  endfunction

  // Accelerator stand-in: drops rdy after a start, busy for a random time, then presents the sum.
  logic acc_busy;
  int   acc_left;
  logic [6:0] acc_size;
  assign xcel_in_rdy = !acc_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_busy <= 0; acc_left <= 0; acc_size <= 0; xcel_result <= 0;
    end else if (!acc_busy) begin
      if (xcel_in_val) begin
        acc_busy <= 1; acc_size <= xcel_in_size; acc_left <= 1 + int'($urandom_range(3, 0));
      end
    end else if (acc_left == 0) begin
      acc_busy <= 0; xcel_result <= mem_sum(acc_size);
    end else begin
      acc_left <= acc_left - 1;
    end
  end

  // Reference model: every accepted request becomes an expected in-order response.
  always @(posedge clk) begin
    if (rst_n && req_val && req_rdy) model_q.push_back(exp_t'{mem_sum(req_size), req_tag});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [6:0] s, input logic [3:0] t);
    req_val = 1; req_size = s; req_tag = t;
    step();
    req_val = 0;
  endtask

  task automatic wait_resp(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (resp_val) begin ok = 1; return; end
      step();
    end
  endtask

  task automatic pop_model(output exp_t e);
    if (model_q.size() != 0) e = model_q.pop_front();
    else e = exp_t'{32'hDEAD_BEEF, 4'hF};
  endtask

  task automatic test_reset();
    rst_n = 0; req_val = 0; req_size = 0; req_tag = 0; resp_rdy = 0;
    #3;
    checks++; if (req_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_rdy: got %b want 1", req_rdy); end
    checks++; if (resp_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_val: got %b want 0", resp_val); end
    checks++; if (xcel_in_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_xcel_in_val: got %b want 0", xcel_in_val); end
    checks++; if (xcel_in_size !== 7'd0) begin errors++; $display("[TB] FAIL reset_xcel_in_size: got %0d want 0", xcel_in_size); end
    checks++; if (done_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_done_count: got %0d want 0", done_count); end
    checks++; if (resp_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_resp_result: got %0d want 0", resp_result); end
    checks++; if (resp_tag !== 4'd0) begin errors++; $display("[TB] FAIL reset_resp_tag: got %0d want 0", resp_tag); end
    step(); step();
    rst_n = 1;
    step();
    checks++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: req_rdy=%b resp_val=%b want 1/0", req_rdy, resp_val); end
  endtask

  task automatic test_single();
    bit ok; exp_t e;
    resp_rdy = 0;
    send(7'd4, 4'd3);
    checks++; if (xcel_in_val !== 1'b1) begin errors++; $display("[TB] FAIL single_launch_val: got %b want 1", xcel_in_val); end
    checks++; if (xcel_in_size !== 7'd4) begin errors++; $display("[TB] FAIL single_launch_size: got %0d want 4", xcel_in_size); end
    wait_resp(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: resp_val=%b want 1", resp_val); end
    pop_model(e);
    checks++; if (resp_result !== 32'd10 || resp_tag !== 4'd3) begin errors++; $display("[TB] FAIL single_resp: got %0d/tag %0d want 10/tag 3", resp_result, resp_tag); end
    resp_rdy = 1;
    step();
    resp_rdy = 0;
    checks++; if (resp_val !== 1'b0) begin errors++; $display("[TB] FAIL single_resp_drop: got %b want 0", resp_val); end
    checks++; if (done_count !== 16'd1) begin errors++; $display("[TB] FAIL single_done_count: got %0d want 1", done_count); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int got = 0; bit hs = 0; bit prev_hs = 0; bit seen2 = 0;
    resp_rdy = 1;
    send(7'd4, 4'd1);
    send(7'd2, 4'd2);
    for (int c = 0; c < 300 && got < 2; c++) begin
      hs = 0;
      if (resp_val) begin
        pop_model(e);
        checks++; if (resp_result !== e.res || resp_tag !== e.tag) begin errors++; $display("[TB] FAIL b2b_resp%0d: got %0d/tag %0d want %0d/tag %0d", got, resp_result, resp_tag, e.res, e.tag); end
        got++; hs = 1;
      end
      if (xcel_in_val && !seen2) begin
        seen2 = 1;
        checks++; if (prev_hs !== 1'b1 || got !== 1) begin errors++; $display("[TB] FAIL b2b_second_launch: prev_handshake=%b responses=%0d want 1/1", prev_hs, got); end
      end
      prev_hs = hs;
      step();
    end
    resp_rdy = 0;
    checks++; if (got !== 2 || !seen2) begin errors++; $display("[TB] FAIL b2b_count: responses=%0d launch_seen=%b want 2/1", got, seen2); end
  endtask

  task automatic test_queue_full();
    int i = 0; bit acc; int got = 0; exp_t e; logic [15:0] dc0;
    logic [31:0] res_exp [5] = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd1};
    dc0 = done_count;
    resp_rdy = 0;
    for (int c = 0; c < 12 && i < 6; c++) begin
      req_val = 1; req_size = 7'((i % 4) + 1); req_tag = 4'(i);
      acc = req_rdy;
      step();
      if (acc) i++;
    end
    checks++; if (i !== 5) begin errors++; $display("[TB] FAIL full_accepted: got %0d want 5", i); end
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_req_rdy: got %b want 0", req_rdy); end
    req_val = 0;
    resp_rdy = 1;
    for (int c = 0; c < 500 && got < 5; c++) begin
      if (resp_val) begin
        pop_model(e);
        checks++; if (resp_result !== res_exp[got] || resp_tag !== 4'(got)) begin errors++; $display("[TB] FAIL full_drain%0d: got %0d/tag %0d want %0d/tag %0d", got, resp_result, resp_tag, res_exp[got], got); end
        got++;
      end
      step();
    end
    resp_rdy = 0;
    checks++; if (got !== 5) begin errors++; $display("[TB] FAIL full_drain_count: got %0d want 5", got); end
    checks++; if (done_count !== dc0 + 16'd5) begin errors++; $display("[TB] FAIL full_done_count: got %0d want %0d", done_count, dc0 + 16'd5); end
  endtask

  task automatic test_backpressure_zero();
    bit ok; exp_t e;
    resp_rdy = 0;
    send(7'd0, 4'd7);
    wait_resp(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: resp_val=%b want 1", resp_val); end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (resp_val !== 1'b1 || resp_result !== 32'd0 || resp_tag !== 4'd7 || xcel_in_val !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: val=%b res=%0d tag=%0d xval=%b want 1/0/7/0", c, resp_val, resp_result, resp_tag, xcel_in_val);
      end
      step();
    end
    pop_model(e);
    resp_rdy = 1;
    step();
    resp_rdy = 0;
    checks++; if (resp_val !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got %b want 0", resp_val); end
  endtask

  task automatic test_random();
    int n = 30; int sent = 0; int got = 0; exp_t e; logic [15:0] dc0;
    dc0 = done_count;
    for (int c = 0; c < 4000 && (sent < n || got < n); c++) begin
      resp_rdy = 1'($urandom_range(1, 0));
      if (resp_val && resp_rdy) begin
        pop_model(e);
        checks++; if (resp_result !== e.res || resp_tag !== e.tag) begin errors++; $display("[TB] FAIL rand_resp%0d: got %0d/tag %0d want %0d/tag %0d", got, resp_result, resp_tag, e.res, e.tag); end
        got++;
      end
      if (sent < n && $urandom_range(1, 0) == 1) begin
        req_val = 1; req_size = 7'($urandom_range(4, 0)); req_tag = 4'($urandom_range(15, 0));
        if (req_rdy) sent++;
      end else begin
        req_val = 0;
      end
      step();
    end
    req_val = 0; resp_rdy = 0;
    checks++; if (got !== n || model_q.size() !== 0) begin errors++; $display("[TB] FAIL rand_count: responses=%0d pending=%0d want %0d/0", got, model_q.size(), n); end
    checks++; if (done_count !== dc0 + 16'(n)) begin errors++; $display("[TB] FAIL rand_done_count: got %0d want %0d", done_count, dc0 + 16'(n)); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok; int seen = 0; exp_t e;
    resp_rdy = 0;
    send(7'd4, 4'd5);
    step(); step();
    rst_n = 0;
    #1;
    model_q.delete();
    checks++;
    if (resp_val !== 1'b0 || xcel_in_val !== 1'b0 || req_rdy !== 1'b1 || done_count !== 16'd0 || resp_result !== 32'd0 || resp_tag !== 4'd0 || xcel_in_size !== 7'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: val=%b xval=%b rdy=%b done=%0d res=%0d tag=%0d size=%0d want 0/0/1/0/0/0/0", resp_val, xcel_in_val, req_rdy, done_count, resp_result, resp_tag, xcel_in_size);
    end
    step(); step();
    rst_n = 1;
    resp_rdy = 1;
    for (int c = 0; c < 20; c++) begin
      if (resp_val) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL midreset_ghost_resp: got %0d responses want 0", seen); end
    resp_rdy = 0;
    send(7'd1, 4'd9);
    wait_resp(200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midreset_timeout: resp_val=%b want 1", resp_val); end
    pop_model(e);
    checks++; if (resp_result !== 32'd1 || resp_tag !== 4'd9) begin errors++; $display("[TB] FAIL midreset_resp: got %0d/tag %0d want 1/tag 9", resp_result, resp_tag); end
    resp_rdy = 1;
    step();
    resp_rdy = 0;
    checks++; if (done_count !== 16'd1) begin errors++; $display("[TB] FAIL midreset_done_count: got %0d want 1", done_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_queue_full();
    test_backpressure_zero();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
